// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared types and helpers for the CPU data memory.
//   WORD_W / ADDR_W : data word and byte-address widths
//   word_t / addr_t : convenience typedefs for those widths
//   word_index()    : byte address -> word index (drops the byte offset,
//                     keeps the low idx_w bits so addresses alias)
// -----------------------------------------------------------------------------
package data_mem_pkg;

   localparam int WORD_W = 32;
   localparam int ADDR_W = 32;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // Bits above idx_w are masked off here, so callers may keep only the
   // low idx_w bits of the result.
   function automatic addr_t word_index(addr_t addr, int idx_w);
      addr_t mask;
      mask = (addr_t'(1) << idx_w) - addr_t'(1);
      return (addr >> 2) & mask;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// DEPTH_WORDS x 32-bit storage with asynchronous clear, one synchronous write
// port and one combinational read port.
// Ports:
//   clk   in   write clock (rising edge)
//   rst   in   asynchronous active-low clear of every word
//   we    in   write enable
//   widx  in   write word index
//   wdata in   write data
//   ridx  in   read word index
//   rdata out  word at ridx (combinational)
// -----------------------------------------------------------------------------
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  word_t            wdata,
   input  logic [IDX_W-1:0] ridx,
   output word_t            rdata
);

   word_t mem [DEPTH_WORDS];

   // Clear is asynchronous so the whole array reads zero the moment rst
   // drops, and writes stay blocked for as long as it is held low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   // Read straight from the array: a same-index write shows up only after
   // the edge that commits it.
   assign rdata = mem[ridx];

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Word-organised data memory for the CPU datapath (lw/sw traffic).
// Byte address in, 32-bit word out; synchronous write, combinational read
// gated by memread. Addresses alias modulo 4*DEPTH_WORDS.
// Ports:
//   clk       in   write clock (rising edge)
//   rst       in   asynchronous active-low reset, clears the memory
//   address   in   byte address; word index = address[IDX_W+1:2]
//   Writedata in   store data
//   memread   in   read enable (readdata is 0 when low)
//   memwrite  in   write enable
//   readdata  out  load data
// Configuration macro:
//   DATAMEM_ALIGN_CHECK_EN - when defined, any access with address[1:0] != 0
//   is misaligned: its write is dropped and its read returns 0. When
//   undefined, address[1:0] is ignored and the containing word is accessed.
// -----------------------------------------------------------------------------
module data_mem
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic  clk,
   input  logic  rst,
   input  addr_t address,
   input  word_t Writedata,
   input  logic  memread,
   input  logic  memwrite,
   output word_t readdata
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   addr_t            idx_full;
   logic [IDX_W-1:0] idx;
   logic             misaligned;
   logic             write_en;
   word_t            array_rdata;

   // Upper index bits are always zero after masking; folded here so the
   // full-width helper result is consumed.
   logic             unused_idx_bits;

   assign idx_full        = word_index(address, IDX_W);
   assign idx             = idx_full[IDX_W-1:0];
   assign unused_idx_bits = ^idx_full[ADDR_W-1:IDX_W];

`ifdef DATAMEM_ALIGN_CHECK_EN
   assign misaligned = |address[1:0];
`else
   assign misaligned = 1'b0;
`endif

   assign write_en = memwrite && !misaligned;

   data_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (write_en),
      .widx  (idx),
      .wdata (Writedata),
      .ridx  (idx),
      .rdata (array_rdata)
   );

   assign readdata = (memread && !misaligned) ? array_rdata : '0;

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
// Directed bench for data_mem: reset clear, write/read, read gating,
// aliasing, simultaneous read/write and misaligned access. Expected values
// follow DATAMEM_ALIGN_CHECK_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_data_mem;

   localparam int DEPTH_WORDS = 1024;

   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic [31:0] Writedata;
   logic        memread;
   logic        memwrite;
   logic [31:0] readdata;

   int n_checks = 0;
   int n_pass   = 0;

   data_mem #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .address   (address),
      .Writedata (Writedata),
      .memread   (memread),
      .memwrite  (memwrite),
      .readdata  (readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Set up a store on the falling edge, commit it on the next rising edge.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      address   = a;
      Writedata = d;
      memwrite  = 1'b1;
      memread   = 1'b0;
      @(posedge clk);
      #1;
      memwrite  = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      address = a;
      memread = 1'b1;
      #1;
      check(tag, readdata, exp);
   endtask

   logic [31:0] exp_mis_20;
   logic [31:0] exp_mis_22;
   logic [31:0] exp_mis_13;

   initial begin
`ifdef DATAMEM_ALIGN_CHECK_EN
      exp_mis_20 = 32'h0000_0002;
      exp_mis_22 = 32'h0000_0000;
      exp_mis_13 = 32'h0000_0000;
`else
      exp_mis_20 = 32'hFFFF_FFFF;
      exp_mis_22 = 32'hFFFF_FFFF;
      exp_mis_13 = 32'hCAFE_F00D;
`endif

      rst       = 1'b0;
      address   = '0;
      Writedata = '0;
      memread   = 1'b1;
      memwrite  = 1'b0;
      #1;
      check("reset_read", readdata, 32'h0);

      // Writes must be blocked while reset is held.
      memwrite  = 1'b1;
      Writedata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      memwrite  = 1'b0;
      check("write_blocked_in_reset", readdata, 32'h0);

      @(negedge clk);
      rst = 1'b1;
      read_chk("post_reset_addr0", 32'h0, 32'h0);

      // Reset clears immediately, mid-cycle.
      do_write(32'h0, 32'h1234_5678);
      read_chk("write_addr0", 32'h0, 32'h1234_5678);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_clear", readdata, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      read_chk("cleared_after_release", 32'h0, 32'h0);

      // Basic write/read and read gating.
      do_write(32'h10, 32'hCAFE_F00D);
      read_chk("read_0x10", 32'h10, 32'hCAFE_F00D);
      memread = 1'b0;
      #1;
      check("gated_0x10", readdata, 32'h0);
      memread = 1'b1;
      #1;
      check("ungated_0x10", readdata, 32'hCAFE_F00D);

      // Idle cycle: memwrite low must not store.
      @(negedge clk);
      address   = 32'h10;
      Writedata = 32'h5555_5555;
      memread   = 1'b0;
      memwrite  = 1'b0;
      #1;
      check("idle_readdata_zero", readdata, 32'h0);
      @(posedge clk);
      #1;
      read_chk("hold_0x10", 32'h10, 32'hCAFE_F00D);

      // Aliasing modulo 4*DEPTH_WORDS.
      do_write(32'(4*DEPTH_WORDS + 8), 32'hA5A5_A5A5);
      read_chk("alias_read_8", 32'h8, 32'hA5A5_A5A5);
      read_chk("alias_read_hi", 32'hFFFF_F008, 32'hA5A5_A5A5);
      read_chk("neighbour_0xc", 32'hC, 32'h0);

      // Simultaneous read and write to the same word.
      do_write(32'h20, 32'h0000_0001);
      @(negedge clk);
      address   = 32'h20;
      Writedata = 32'h0000_0002;
      memread   = 1'b1;
      memwrite  = 1'b1;
      #1;
      check("rw_before_edge", readdata, 32'h1);
      @(posedge clk);
      #1;
      memwrite = 1'b0;
      check("rw_after_edge", readdata, 32'h2);

      // Misaligned accesses.
      do_write(32'h22, 32'hFFFF_FFFF);
      read_chk("misaligned_write_0x20", 32'h20, exp_mis_20);
      read_chk("misaligned_read_0x22", 32'h22, exp_mis_22);
      read_chk("misaligned_read_0x13", 32'h13, exp_mis_13);
      read_chk("neighbour_0x24", 32'h24, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Safety bound on total run time.
   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
